alu: RTL and testbench

- 4-bit ALU for the E0C6200-style CPU core.
- Computes result, carry and zero combinationally from two operand nibbles, an opcode, and the incoming carry and decimal flags.
- Registered copies of the result and flags are also provided for the CPU's flag/writeback stage.

---
 rtl/alu.sv | 146 ++++++++++++++
 tb/tb_alu.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 4-bit ALU for an E0C6200-style CPU core.
//
// Produces result, carry and zero from two operand nibbles, an opcode and the
// incoming carry/decimal flags. The combinational outputs have zero latency;
// registered copies feed the CPU's flag/writeback stage.
//
// Ports:
//   clk             system clock, rising edge updates the registered outputs
//   reset           asynchronous active-high, clears the registered outputs
//   op              alu_op (ADD=0 .. CP=11, 12-15 pass A through)
//   temp_a, temp_b  operand nibbles A and B
//   flag_carry_in   current C flag
//   flag_decimal_in current D flag (BCD mode)
//   out             combinational result
//   flag_carry_out  combinational new C
//   flag_zero_out   combinational new Z (out == 0)
//   out_q           out registered on clk
//   flag_carry_q    flag_carry_out registered on clk
//   flag_zero_q     flag_zero_out registered on clk
// ---------------------------------------------------------------------------
module alu (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] op,
  input  logic [3:0] temp_a,
  input  logic [3:0] temp_b,
  input  logic       flag_carry_in,
  input  logic       flag_decimal_in,
  output logic [3:0] out,
  output logic       flag_carry_out,
  output logic       flag_zero_out,
  output logic [3:0] out_q,
  output logic       flag_carry_q,
  output logic       flag_zero_q
);

  localparam logic [3:0] OP_ADD        = 4'd0;
  localparam logic [3:0] OP_ADC        = 4'd1;
  localparam logic [3:0] OP_ADC_NO_DEC = 4'd2;
  localparam logic [3:0] OP_SUB        = 4'd3;
  localparam logic [3:0] OP_SBC        = 4'd4;
  localparam logic [3:0] OP_AND        = 4'd5;
  localparam logic [3:0] OP_OR         = 4'd6;
  localparam logic [3:0] OP_XOR        = 4'd7;
  localparam logic [3:0] OP_RRC        = 4'd8;
  localparam logic [3:0] OP_RLC        = 4'd9;
  localparam logic [3:0] OP_NOT        = 4'd10;
  localparam logic [3:0] OP_CP         = 4'd11;

  // BCD add adjust: returns {carry, digit}. Sums up to 31 are possible, so
  // the digit wraps modulo 16 (15+15+1 -> 5 with carry).
  function automatic logic [4:0] bcd_add_adjust(input logic [4:0] sum);
    logic [4:0] t;
    t = sum - 5'd10;
    if (sum >= 5'd10) return {1'b1, t[3:0]};
    else              return {1'b0, sum[3:0]};
  endfunction

  // BCD subtract adjust: only a borrow triggers the +10 correction; a
  // non-borrowing result >= 10 is deliberately left alone.
  function automatic logic [3:0] bcd_sub_adjust(input logic [4:0] diff,
                                                input logic       borrow);
    logic [4:0] t;
    t = diff + 5'd10;
    if (borrow) return t[3:0];
    else        return diff[3:0];
  endfunction

  logic              cin_eff;
  logic        [4:0] sum;
  logic signed [5:0] diff;
  logic signed [5:0] cmp;
  logic        [4:0] adj;
  logic        [3:0] res;
  logic              cy;

  // Carry-in only participates in the "with carry" forms.
  assign cin_eff = (op == OP_ADC || op == OP_ADC_NO_DEC || op == OP_SBC) ?
                   flag_carry_in : 1'b0;

  assign sum  = {1'b0, temp_a} + {1'b0, temp_b} + {4'b0, cin_eff};
  // Negative difference means a borrow out of the nibble.
  assign diff = $signed({2'b00, temp_a}) - $signed({2'b00, temp_b})
              - $signed({5'b00000, cin_eff});
  assign cmp  = $signed({2'b00, temp_a}) - $signed({2'b00, temp_b});
  assign adj  = bcd_add_adjust(sum);

  always_comb begin
    res = temp_a;
    cy  = flag_carry_in;
    case (op)
      OP_ADD, OP_ADC, OP_ADC_NO_DEC: begin
        if (flag_decimal_in && op != OP_ADC_NO_DEC) begin
          res = adj[3:0];
          cy  = adj[4];
        end else begin
          res = sum[3:0];
          cy  = sum[4];
        end
      end
      OP_SUB, OP_SBC: begin
        cy  = (diff < 0);
        res = flag_decimal_in ? bcd_sub_adjust(diff[4:0], diff < 0) : diff[3:0];
      end
      OP_AND: res = temp_a & temp_b;
      OP_OR:  res = temp_a | temp_b;
      OP_XOR: res = temp_a ^ temp_b;
      OP_RRC: begin
        res = {flag_carry_in, temp_a[3:1]};
        cy  = temp_a[0];
      end
      OP_RLC: begin
        res = {temp_a[2:0], flag_carry_in};
        cy  = temp_a[3];
      end
      OP_NOT: res = ~temp_a;
      OP_CP: begin
        res = cmp[3:0];
        cy  = (cmp < 0);
      end
      default: begin
        res = temp_a;
        cy  = flag_carry_in;
      end
    endcase
  end

  assign out            = res;
  assign flag_carry_out = cy;
  assign flag_zero_out  = (res == 4'd0);

  // Stage boundary: writeback/flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= 4'd0;
      flag_carry_q <= 1'b0;
      flag_zero_q  <= 1'b0;
    end else begin
      out_q        <= out;
      flag_carry_q <= flag_carry_out;
      flag_zero_q  <= flag_zero_out;
    end
  end

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic       clk;
  logic       reset;
  logic [3:0] op;
  logic [3:0] temp_a;
  logic [3:0] temp_b;
  logic       flag_carry_in;
  logic       flag_decimal_in;
  logic [3:0] out;
  logic       flag_carry_out;
  logic       flag_zero_out;
  logic [3:0] out_q;
  logic       flag_carry_q;
  logic       flag_zero_q;

  int total = 0;
  int bad   = 0;
  int vec_id = 0;

  typedef struct {
    int         id;
    logic [3:0] e_out;
    logic       e_c;
    logic       e_z;
  } exp_t;

  exp_t sb[$];

  alu dut (
    .clk            (clk),
    .reset          (reset),
    .op             (op),
    .temp_a         (temp_a),
    .temp_b         (temp_b),
    .flag_carry_in  (flag_carry_in),
    .flag_decimal_in(flag_decimal_in),
    .out            (out),
    .flag_carry_out (flag_carry_out),
    .flag_zero_out  (flag_zero_out),
    .out_q          (out_q),
    .flag_carry_q   (flag_carry_q),
    .flag_zero_q    (flag_zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int id,
                       input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec%0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Drive one vector at the falling edge and post its expected response.
  task automatic apply(input logic [3:0] o, input logic [3:0] a,
                       input logic [3:0] b, input logic cin, input logic dec,
                       input logic [3:0] e_out, input logic e_c,
                       input logic e_z);
    exp_t e;
    @(negedge clk);
    op = o; temp_a = a; temp_b = b;
    flag_carry_in = cin; flag_decimal_in = dec;
    vec_id++;
    e.id = vec_id; e.e_out = e_out; e.e_c = e_c; e.e_z = e_z;
    sb.push_back(e);
  endtask

  // Monitor: after each rising edge, the combinational outputs still show the
  // current vector and the registers have just captured it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out",   e.id, out,                    e.e_out);
        check("c",     e.id, {3'b0, flag_carry_out}, {3'b0, e.e_c});
        check("z",     e.id, {3'b0, flag_zero_out},  {3'b0, e.e_z});
        check("out_q", e.id, out_q,                  e.e_out);
        check("c_q",   e.id, {3'b0, flag_carry_q},   {3'b0, e.e_c});
        check("z_q",   e.id, {3'b0, flag_zero_q},    {3'b0, e.e_z});
      end
    end
  end

  initial begin
    int waited;
    reset = 1'b1;
    op = 4'd0; temp_a = 4'd0; temp_b = 4'd0;
    flag_carry_in = 1'b0; flag_decimal_in = 1'b0;
    #2;
    check("rst_out_q", 0, out_q,                  4'd0);
    check("rst_c_q",   0, {3'b0, flag_carry_q},   4'd0);
    check("rst_z_q",   0, {3'b0, flag_zero_q},    4'd0);
    @(negedge clk);
    reset = 1'b0;

    //     op     A      B      cin   dec   out    C     Z
    // Binary add
    apply(4'd0,  4'd10, 4'd10, 1'b1, 1'b0, 4'd4,  1'b1, 1'b0);
    apply(4'd1,  4'd7,  4'd8,  1'b1, 1'b0, 4'd0,  1'b1, 1'b1);
    apply(4'd1,  4'd7,  4'd8,  1'b0, 1'b0, 4'd15, 1'b0, 1'b0);
    // BCD add
    apply(4'd0,  4'd9,  4'd0,  1'b1, 1'b1, 4'd9,  1'b0, 1'b0);
    apply(4'd1,  4'd9,  4'd0,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1);
    apply(4'd1,  4'd0,  4'd15, 1'b0, 1'b1, 4'd5,  1'b1, 1'b0);
    apply(4'd2,  4'd9,  4'd0,  1'b1, 1'b1, 4'd10, 1'b0, 1'b0);
    apply(4'd1,  4'd15, 4'd15, 1'b1, 1'b1, 4'd5,  1'b1, 1'b0);
    apply(4'd0,  4'd10, 4'd15, 1'b0, 1'b1, 4'd15, 1'b1, 1'b0);
    // Subtract
    apply(4'd4,  4'd0,  4'd0,  1'b1, 1'b0, 4'hF,  1'b1, 1'b0);
    apply(4'd4,  4'd10, 4'd15, 1'b1, 1'b0, 4'hA,  1'b1, 1'b0);
    apply(4'd3,  4'd15, 4'd10, 1'b1, 1'b0, 4'd5,  1'b0, 1'b0);
    apply(4'd3,  4'd4,  4'd15, 1'b0, 1'b1, 4'hF,  1'b1, 1'b0);
    apply(4'd4,  4'd0,  4'd9,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1);
    apply(4'd4,  4'd15, 4'd1,  1'b1, 1'b1, 4'd13, 1'b0, 1'b0);
    // Logic / rotate
    apply(4'd5,  4'hA,  4'h8,  1'b0, 1'b0, 4'h8,  1'b0, 1'b0);
    apply(4'd7,  4'hA,  4'h7,  1'b1, 1'b0, 4'hD,  1'b1, 1'b0);
    apply(4'd6,  4'hA,  4'hC,  1'b0, 1'b0, 4'hE,  1'b0, 1'b0);
    apply(4'd8,  4'h1,  4'h5,  1'b0, 1'b0, 4'h0,  1'b1, 1'b1);
    apply(4'd9,  4'hF,  4'h0,  1'b0, 1'b0, 4'hE,  1'b1, 1'b0);
    apply(4'd9,  4'h1,  4'h0,  1'b1, 1'b0, 4'h3,  1'b0, 1'b0);
    apply(4'd10, 4'h3,  4'h0,  1'b1, 1'b0, 4'hC,  1'b1, 1'b0);
    // Compare
    apply(4'd11, 4'd0,  4'd0,  1'b1, 1'b0, 4'd0,  1'b0, 1'b1);
    apply(4'd11, 4'd0,  4'd1,  1'b1, 1'b0, 4'hF,  1'b1, 1'b0);
    apply(4'd11, 4'd15, 4'd1,  1'b1, 1'b1, 4'hE,  1'b0, 1'b0);
    // Undefined opcode passes A
    apply(4'd12, 4'd6,  4'd3,  1'b1, 1'b0, 4'd6,  1'b1, 1'b0);

    // Mid-run async reset: registers hold a nonzero result, then clear
    // without waiting for an edge.
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_out_q", 0, out_q,                4'd0);
    check("mid_rst_c_q",   0, {3'b0, flag_carry_q}, 4'd0);
    check("mid_rst_z_q",   0, {3'b0, flag_zero_q},  4'd0);
    @(negedge clk);
    reset = 1'b0;
    apply(4'd1,  4'd7,  4'd8,  1'b1, 1'b0, 4'd0,  1'b1, 1'b1);

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
